// File: rtl/bpm_link_packet_monitor.sv
// Per-direction BPM packet checker on the Aurora user clock: validates header magic,
// word count and Aurora CRC, and emits one status strobe and code per packet.
module bpm_link_packet_monitor #(
    parameter int          PACKET_WORDS    = 6,
    parameter logic [15:0] MAGIC           = 16'hA5BE,
    parameter int          CRC_WAIT_CYCLES = 8
) (
    input  logic        auroraUserClk,
    input  logic        auroraUserResetN,
    input  logic        channelUp,
    input  logic        rxTVALID,
    input  logic [31:0] rxTDATA,
    input  logic        rxTLAST,
    input  logic        crcValid,
    input  logic        crcPass,
    output logic        statusStrobe,
    output logic [1:0]  statusCode,
    output logic [7:0]  bpmIndex,
    output logic [1:0]  debugState
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BODY     = 2'd1,
        DISCARD  = 2'd2,
        CRC_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT  = 8'(PACKET_WORDS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(CRC_WAIT_CYCLES - 1);

    state_t     state, stateN;
    logic [7:0] wordCnt, wordCntN, waitCnt, waitCntN;
    logic [7:0] candIdx, candIdxN, finIdx, tailIdx;
    logic [1:0] pend, pendN, finCode, hdrCode, tailCode;
    logic       fin, takeHdr, tailSeen;
    logic       unusedDataBits;

    assign unusedDataBits = ^rxTDATA[15:8];
    assign debugState     = state;

    // Outcome codes are ordered by severity, so merging is a plain max.
    function automatic logic [1:0] merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        stateN   = state;
        wordCntN = wordCnt;
        waitCntN = waitCnt;
        pendN    = pend;
        candIdxN = candIdx;
        fin      = 1'b0;
        finCode  = pend;
        finIdx   = candIdx;
        hdrCode  = 2'd0;
        tailCode = pend;
        tailIdx  = candIdx;
        takeHdr  = 1'b0;
        tailSeen = 1'b0;

        if (!channelUp) begin
            if (state != IDLE) begin
                fin     = 1'b1;
                finCode = merge(pend, 2'd2);
                stateN  = IDLE;
            end
        end else begin
            case (state)
                IDLE: takeHdr = rxTVALID;
                BODY: begin
                    if (rxTVALID) begin
                        wordCntN = wordCnt + 8'd1;
                        if (rxTLAST) begin
                            tailSeen = 1'b1;
                            tailCode = (wordCnt == LAST_CNT) ? pend : merge(pend, 2'd2);
                        end else if (wordCnt == LAST_CNT) begin
                            pendN  = merge(pend, 2'd2);
                            stateN = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (rxTVALID && rxTLAST) begin
                        tailSeen = 1'b1;
                        tailCode = pend;
                    end
                end
                CRC_WAIT: begin
                    waitCntN = waitCnt + 8'd1;
                    if (crcValid) begin
                        fin     = 1'b1;
                        finCode = crcPass ? pend : 2'd3;
                        stateN  = IDLE;
                    end else if (rxTVALID || waitCnt == WAIT_LAST) begin
                        fin     = 1'b1;
                        finCode = 2'd3;
                        stateN  = IDLE;
                    end
                    // A new header preempts the wait and starts the next packet this cycle.
                    takeHdr = rxTVALID;
                end
                default: stateN = IDLE;
            endcase

            if (takeHdr) begin
                hdrCode  = (rxTDATA[31:16] != MAGIC) ? 2'd1 : 2'd0;
                candIdxN = rxTDATA[7:0];
                if (rxTLAST) begin
                    tailSeen = 1'b1;
                    tailCode = merge(hdrCode, 2'd2);
                    tailIdx  = rxTDATA[7:0];
                end else begin
                    pendN    = hdrCode;
                    wordCntN = 8'd1;
                    stateN   = BODY;
                end
            end

            // A crcValid in a preempting cycle belongs to the packet being closed.
            if (tailSeen) begin
                if (crcValid && state != CRC_WAIT) begin
                    fin     = 1'b1;
                    finCode = crcPass ? tailCode : 2'd3;
                    finIdx  = tailIdx;
                    stateN  = IDLE;
                end else begin
                    pendN    = tailCode;
                    waitCntN = 8'd0;
                    stateN   = CRC_WAIT;
                end
            end
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (!auroraUserResetN) begin
            state        <= IDLE;
            wordCnt      <= 8'd0;
            waitCnt      <= 8'd0;
            pend         <= 2'd0;
            candIdx      <= 8'd0;
            statusStrobe <= 1'b0;
            statusCode   <= 2'd0;
            bpmIndex     <= 8'd0;
        end else begin
            state        <= stateN;
            wordCnt      <= wordCntN;
            waitCnt      <= waitCntN;
            pend         <= pendN;
            candIdx      <= candIdxN;
            statusStrobe <= fin;
            if (fin) begin
                statusCode <= finCode;
                if (finCode == 2'd0) begin
                    bpmIndex <= finIdx;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpm_link_packet_monitor.sv
// Directed, table-driven bench for bpm_link_packet_monitor: one row per clock cycle
// holding the inputs and the outputs expected just after that edge.
module tb_bpm_link_packet_monitor;

    typedef struct {
        logic        rstN;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        cv;
        logic        cp;
        logic        up;
        logic        es;
        logic [1:0]  ec;
        logic [7:0]  ei;
    } vec_t;

    logic        sysClk = 1'b0;
    logic        auroraUserResetN = 1'b0;
    logic        channelUp = 1'b1;
    logic        rxTVALID = 1'b0;
    logic [31:0] rxTDATA = 32'd0;
    logic        rxTLAST = 1'b0;
    logic        crcValid = 1'b0;
    logic        crcPass = 1'b0;
    logic        statusStrobe;
    logic [1:0]  statusCode;
    logic [7:0]  bpmIndex;
    logic [1:0]  debugState;

    vec_t        vecs[$];
    logic [1:0]  ecCur = 2'd0;
    logic [7:0]  eiCur = 8'd0;
    int          vecCount = 0;
    int          missCount = 0;

    always #5 sysClk = ~sysClk;

    bpm_link_packet_monitor dut (
        .auroraUserClk   (sysClk),
        .auroraUserResetN(auroraUserResetN),
        .channelUp       (channelUp),
        .rxTVALID        (rxTVALID),
        .rxTDATA         (rxTDATA),
        .rxTLAST         (rxTLAST),
        .crcValid        (crcValid),
        .crcPass         (crcPass),
        .statusStrobe    (statusStrobe),
        .statusCode      (statusCode),
        .bpmIndex        (bpmIndex),
        .debugState      (debugState)
    );

    // Row with no strobe expected; code/index hold their last values.
    task automatic w(input logic v, input logic [31:0] d, input logic l,
                     input logic cv, input logic cp, input logic up);
        vecs.push_back('{1'b1, v, d, l, cv, cp, up, 1'b0, ecCur, eiCur});
    endtask

    // Row whose edge decides a packet: strobe with the given code/index.
    task automatic ws(input logic v, input logic [31:0] d, input logic l,
                      input logic cv, input logic cp, input logic up,
                      input logic [1:0] c, input logic [7:0] ix);
        ecCur = c;
        eiCur = ix;
        vecs.push_back('{1'b1, v, d, l, cv, cp, up, 1'b1, ecCur, eiCur});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) w(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic body(input int n);
        for (int i = 0; i < n; i++) w(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic apply(input vec_t t, input string name);
        @(negedge sysClk);
        auroraUserResetN = t.rstN;
        rxTVALID         = t.v;
        rxTDATA          = t.d;
        rxTLAST          = t.l;
        crcValid         = t.cv;
        crcPass          = t.cp;
        channelUp        = t.up;
        @(posedge sysClk);
        #1;
        vecCount++;
        if (statusStrobe !== t.es) begin
            missCount++;
            $display("FAIL %s strobe: got %0b expected %0b", name, statusStrobe, t.es);
        end
        if (statusCode !== t.ec) begin
            missCount++;
            $display("FAIL %s code: got %0d expected %0d", name, statusCode, t.ec);
        end
        if (bpmIndex !== t.ei) begin
            missCount++;
            $display("FAIL %s index: got %0h expected %0h", name, bpmIndex, t.ei);
        end
    endtask

    initial begin
        // Good 6-word packet; a stray crcValid in BODY must be ignored.
        w(1, 32'hA5BE_0017, 0, 0, 0, 1);
        w(1, 32'h0000_0002, 0, 1, 0, 1);
        body(3);
        ws(1, 32'h0000_0006, 1, 1, 1, 1, 2'd0, 8'h17);
        idle(1);
        // Bad magic, correct length, CRC pass.
        w(1, 32'h1234_0005, 0, 0, 0, 1);
        body(4);
        ws(1, 32'h0000_0006, 1, 1, 1, 1, 2'd1, 8'h17);
        idle(1);
        // Short 4-word packet.
        w(1, 32'hA5BE_0021, 0, 0, 0, 1);
        body(2);
        ws(1, 32'h0000_0004, 1, 1, 1, 1, 2'd2, 8'h17);
        idle(1);
        // Long 8-word packet: single strobe after the 8th word.
        w(1, 32'hA5BE_0022, 0, 0, 0, 1);
        body(6);
        ws(1, 32'h0000_0008, 1, 1, 1, 1, 2'd2, 8'h17);
        idle(2);
        // Bad magic with CRC fail: CRC code wins.
        w(1, 32'h1234_0009, 0, 0, 0, 1);
        body(4);
        ws(1, 32'h0000_0006, 1, 1, 0, 1, 2'd3, 8'h17);
        idle(1);
        // Good packet, crcValid never arrives: timeout 8 cycles after CRC_WAIT entry.
        w(1, 32'hA5BE_0042, 0, 0, 0, 1);
        body(4);
        w(1, 32'h0000_0006, 1, 0, 0, 1);
        idle(7);
        ws(0, 32'd0, 0, 0, 0, 1, 2'd3, 8'h17);
        idle(1);
        // Back-to-back: next header preempts pending CRC, second packet is good.
        w(1, 32'hA5BE_0050, 0, 0, 0, 1);
        body(4);
        w(1, 32'h0000_0006, 1, 0, 0, 1);
        ws(1, 32'hA5BE_0055, 0, 0, 0, 1, 2'd3, 8'h17);
        body(4);
        ws(1, 32'h0000_0006, 1, 1, 1, 1, 2'd0, 8'h55);
        idle(1);
        // 1-word packet is always a length error.
        ws(1, 32'hA5BE_0060, 1, 1, 1, 1, 2'd2, 8'h55);
        idle(1);
        // Good packet whose crcValid arrives in the third CRC_WAIT cycle.
        w(1, 32'hA5BE_0066, 0, 0, 0, 1);
        body(4);
        w(1, 32'h0000_0006, 1, 0, 0, 1);
        idle(2);
        ws(0, 32'd0, 0, 1, 1, 1, 2'd0, 8'h66);
        idle(1);
        // channelUp drops at word 3; words ignored while down.
        w(1, 32'hA5BE_0077, 0, 0, 0, 1);
        w(1, 32'h0000_0002, 0, 0, 0, 1);
        ws(1, 32'h0000_0003, 0, 0, 0, 0, 2'd2, 8'h66);
        w(1, 32'hA5BE_0078, 0, 0, 0, 0);
        w(1, 32'hA5BE_0079, 1, 1, 1, 0);
        idle(1);
        // Link back up: next packet is checked normally.
        w(1, 32'h1234_0001, 0, 0, 0, 1);
        body(4);
        ws(1, 32'h0000_0006, 1, 1, 1, 1, 2'd1, 8'h66);
        idle(1);

        // Reset state.
        auroraUserResetN = 1'b0;
        repeat (2) @(posedge sysClk);
        apply('{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Reset asserted mid-packet: no strobe, all outputs cleared.
        apply('{1'b1, 1'b1, 32'hA5BE_00AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h66}, "mid_hdr");
        apply('{1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h66}, "mid_w2");
        apply('{1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "mid_reset");
        for (int i = 0; i < 3; i++) begin
            apply('{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "post_reset_idle");
        end
        apply('{1'b1, 1'b1, 32'hA5BE_00BB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "post_hdr");
        for (int i = 0; i < 4; i++) begin
            apply('{1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "post_body");
        end
        apply('{1'b1, 1'b1, 32'h0000_0206, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'hBB}, "post_last");
        apply('{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'hBB}, "post_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
